// File: rtl/mul_result_collector_if.sv
// Snoop/handshake bundle between the MiniAlu RAM write port, the collector and its consumer.
// oLed is present only when COLLECTOR_LED_EN is defined.
interface mul_result_collector_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8
) ();
  logic                    iMulActive;
  logic                    iWriteEnable;
  logic [7:0]              iWriteAddress;
  logic [15:0]             iDataIn;
  logic                    iAck;
  logic [LANES*LANE_W-1:0] oWord;
  logic [7:0]              oAddr;
  logic                    oValid;
  logic                    oAbort;
  logic                    oOverrun;
`ifdef COLLECTOR_LED_EN
  logic [LANE_W-1:0]       oLed;

  modport master (
    output iMulActive, iWriteEnable, iWriteAddress, iDataIn, iAck,
    input  oWord, oAddr, oValid, oAbort, oOverrun, oLed
  );
  modport slave (
    input  iMulActive, iWriteEnable, iWriteAddress, iDataIn, iAck,
    output oWord, oAddr, oValid, oAbort, oOverrun, oLed
  );
`else
  modport master (
    output iMulActive, iWriteEnable, iWriteAddress, iDataIn, iAck,
    input  oWord, oAddr, oValid, oAbort, oOverrun
  );
  modport slave (
    input  iMulActive, iWriteEnable, iWriteAddress, iDataIn, iAck,
    output oWord, oAddr, oValid, oAbort, oOverrun
  );
`endif
endinterface

// File: rtl/mul_result_collector.sv
// Reassembles the byte-serial MUL result (LSB first) into one word with a valid/ack handshake.
// Optional LED byte display is enabled by defining COLLECTOR_LED_EN.
module mul_result_collector #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8
`ifdef COLLECTOR_LED_EN
  ,
  parameter int unsigned LED_PRESC_W = 24
`endif
) (
  input logic                    Clock,
  input logic                    Reset,
  mul_result_collector_if.slave  bus
);
  localparam int unsigned         LaneCntW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned         WordW    = LANES * LANE_W;
  localparam logic [LaneCntW-1:0] LastLane = LaneCntW'(LANES - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StHold, StDrain} state_e;

  state_e              state_q, state_d;
  logic [LaneCntW-1:0] lane_q, lane_d;
  logic [WordW-1:0]    shadow_q, shadow_d;
  logic [WordW-1:0]    word_q, word_d;
  logic [7:0]          addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                abort_q, abort_d;
  logic                overrun_q, overrun_d;
  logic                drop_q, drop_d;
  logic                start_new;

  logic              beat;
  logic [LANE_W-1:0] byte_in;
  logic              unused_data;

  assign beat        = bus.iMulActive & bus.iWriteEnable;
  assign byte_in     = bus.iDataIn[LANE_W-1:0];
  assign unused_data = ^bus.iDataIn;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    shadow_d  = shadow_q;
    word_d    = word_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    abort_d   = 1'b0;
    overrun_d = overrun_q;
    drop_d    = drop_q;
    start_new = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (beat) start_new = 1'b1;
      end
      StCollect: begin
        if (!bus.iMulActive) begin
          abort_d = 1'b1;
          lane_d  = '0;
          state_d = StIdle;
        end else if (beat && (bus.iWriteAddress != addr_q)) begin
          abort_d   = 1'b1;
          start_new = 1'b1;
        end else if (beat) begin
          shadow_d[32'(lane_q) * LANE_W +: LANE_W] = byte_in;
          if (lane_q == LastLane) begin
            // Publish the completed shadow in one step so oWord never mixes products.
            word_d  = shadow_d;
            valid_d = 1'b1;
            drop_d  = 1'b0;
            lane_d  = '0;
            state_d = StHold;
          end else begin
            lane_d = lane_q + LaneCntW'(1);
          end
        end
      end
      StHold: begin
        if (bus.iAck) begin
          valid_d = 1'b0;
          drop_d  = 1'b0;
          if (drop_q) begin
            // Rest of the dropped MUL must pass before a new product may start.
            state_d = bus.iMulActive ? StDrain : StIdle;
          end else if (beat) begin
            start_new = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (beat) begin
          overrun_d = 1'b1;
          drop_d    = 1'b1;
        end else if (!bus.iMulActive) begin
          drop_d = 1'b0;
        end
      end
      StDrain: begin
        if (!bus.iMulActive) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start_new) begin
      shadow_d               = '0;
      shadow_d[LANE_W-1:0]   = byte_in;
      addr_d                 = bus.iWriteAddress;
      lane_d                 = LaneCntW'(1);
      state_d                = StCollect;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      lane_q    <= '0;
      shadow_q  <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      shadow_q  <= shadow_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      abort_q   <= abort_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.oWord    = word_q;
  assign bus.oAddr    = addr_q;
  assign bus.oValid   = valid_q;
  assign bus.oAbort   = abort_q;
  assign bus.oOverrun = overrun_q;

`ifdef COLLECTOR_LED_EN
  logic [LED_PRESC_W-1:0] presc_q, presc_d;
  logic [LaneCntW-1:0]    disp_q, disp_d;

  // Valid is always low on the cycle before HOLD entry, so the display restarts at lane 0.
  always_comb begin
    presc_d = '0;
    disp_d  = '0;
    if (valid_q) begin
      presc_d = presc_q + LED_PRESC_W'(1);
      disp_d  = disp_q;
      if (presc_q == '1) disp_d = (disp_q == LastLane) ? '0 : disp_q + LaneCntW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      presc_q <= '0;
      disp_q  <= '0;
    end else begin
      presc_q <= presc_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.oLed = valid_q ? word_q[32'(disp_q) * LANE_W +: LANE_W] : '0;
`else
  // No display logic in this build.
`endif
endmodule

// File: tb/tb_mul_result_collector.sv
// Self-checking bench for mul_result_collector: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_mul_result_collector;
  logic        clk;
  logic        rst;
  logic        mul;
  logic        we;
  logic [7:0]  waddr;
  logic [15:0] wdata;
  logic        ack;

  int errors = 0;
  int checks = 0;

  mul_result_collector_if #(.LANES(4), .LANE_W(8)) bus_if ();

  assign bus_if.iMulActive    = mul;
  assign bus_if.iWriteEnable  = we;
  assign bus_if.iWriteAddress = waddr;
  assign bus_if.iDataIn       = wdata;
  assign bus_if.iAck          = ack;

  mul_result_collector #(
    .LANES (4),
    .LANE_W(8)
`ifdef COLLECTOR_LED_EN
    ,
    .LED_PRESC_W(3)
`endif
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: partial product as a byte queue, plus the handshake/overrun flags.
  logic [7:0]  part[$];
  logic [7:0]  paddr_m;
  logic [31:0] word_m;
  bit          held_m, drop_m, drain_m, ovr_m, abort_m;

  task automatic model_start(input logic [7:0] b, input logic [7:0] a);
    part.delete();
    part.push_back(b);
    paddr_m = a;
  endtask

  task automatic model_step();
    logic beat_m;
    beat_m  = mul & we;
    abort_m = 1'b0;
    if (rst) begin
      part.delete();
      paddr_m = '0; word_m = '0;
      held_m = 0; drop_m = 0; drain_m = 0; ovr_m = 0;
    end else if (held_m) begin
      if (ack) begin
        held_m = 0;
        if (drop_m) begin
          drop_m  = 0;
          drain_m = mul;
        end else if (beat_m) begin
          model_start(wdata[7:0], waddr);
        end
      end else if (beat_m) begin
        ovr_m  = 1;
        drop_m = 1;
      end else if (!mul) begin
        drop_m = 0;
      end
    end else if (drain_m) begin
      if (!mul) drain_m = 0;
    end else if (part.size() == 0) begin
      if (beat_m) model_start(wdata[7:0], waddr);
    end else if (!mul) begin
      abort_m = 1;
      part.delete();
    end else if (beat_m && waddr != paddr_m) begin
      abort_m = 1;
      model_start(wdata[7:0], waddr);
    end else if (beat_m) begin
      part.push_back(wdata[7:0]);
      if (part.size() == 4) begin
        word_m = 0;
        foreach (part[i]) word_m = word_m | (32'(part[i]) << (8 * i));
        held_m = 1;
        part.delete();
      end
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic beat_tick(input logic [7:0] a, input logic [7:0] d);
    mul   = 1'b1;
    we    = 1'b1;
    waddr = a;
    wdata = {8'($urandom), d};
    tick();
    we = 1'b0;
  endtask

  task automatic release_word();
    mul = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; mul = 1'b0; we = 1'b0; ack = 1'b0; waddr = '0; wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus_if.oValid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %0h want 0", bus_if.oValid); end
    checks++; if (bus_if.oWord !== 32'h0) begin errors++;
      $display("FAIL reset_word: got %h want 0", bus_if.oWord); end
    checks++; if (bus_if.oAddr !== 8'h0) begin errors++;
      $display("FAIL reset_addr: got %h want 0", bus_if.oAddr); end
    checks++; if (bus_if.oAbort !== 1'b0) begin errors++;
      $display("FAIL reset_abort: got %0h want 0", bus_if.oAbort); end
    checks++; if (bus_if.oOverrun !== 1'b0) begin errors++;
      $display("FAIL reset_overrun: got %0h want 0", bus_if.oOverrun); end
  endtask

  task automatic test_basic();
    beat_tick(8'h05, 8'h78);
    beat_tick(8'h05, 8'h56);
    beat_tick(8'h05, 8'h34);
    checks++; if (bus_if.oValid !== 1'b0) begin errors++;
      $display("FAIL basic_early_valid: got %0h want 0", bus_if.oValid); end
    beat_tick(8'h05, 8'h12);
    checks++; if (bus_if.oValid !== 1'b1) begin errors++;
      $display("FAIL basic_valid: got %0h want 1", bus_if.oValid); end
    checks++; if (bus_if.oWord !== 32'h12345678) begin errors++;
      $display("FAIL basic_word: got %h want 12345678", bus_if.oWord); end
    checks++; if (bus_if.oAddr !== 8'h05) begin errors++;
      $display("FAIL basic_addr: got %h want 05", bus_if.oAddr); end
    mul = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (bus_if.oValid !== 1'b0) begin errors++;
      $display("FAIL basic_ack: got %0h want 0", bus_if.oValid); end
  endtask

  task automatic test_abort();
    logic [7:0] d[4];
    beat_tick(8'h05, 8'hAA);
    beat_tick(8'h05, 8'hBB);
    mul = 1'b0;
    tick();
    checks++; if (bus_if.oAbort !== 1'b1) begin errors++;
      $display("FAIL abort_pulse: got %0h want 1", bus_if.oAbort); end
    checks++; if (bus_if.oValid !== 1'b0) begin errors++;
      $display("FAIL abort_valid: got %0h want 0", bus_if.oValid); end
    tick();
    checks++; if (bus_if.oAbort !== 1'b0) begin errors++;
      $display("FAIL abort_width: got %0h want 0", bus_if.oAbort); end
    foreach (d[i]) begin
      d[i] = 8'($urandom);
      beat_tick(8'h05, d[i]);
    end
    checks++; if (bus_if.oWord !== {d[3], d[2], d[1], d[0]} || bus_if.oValid !== 1'b1) begin
      errors++;
      $display("FAIL abort_recollect: got %h/%0h want %h/1", bus_if.oWord, bus_if.oValid,
               {d[3], d[2], d[1], d[0]});
    end
    release_word();
  endtask

  task automatic test_overrun();
    beat_tick(8'h05, 8'h01); beat_tick(8'h05, 8'h02);
    beat_tick(8'h05, 8'h03); beat_tick(8'h05, 8'h04);
    mul = 1'b0;
    tick();
    beat_tick(8'h05, 8'h55);
    checks++; if (bus_if.oOverrun !== 1'b1) begin errors++;
      $display("FAIL overrun_flag: got %0h want 1", bus_if.oOverrun); end
    beat_tick(8'h05, 8'h66); beat_tick(8'h05, 8'h77); beat_tick(8'h05, 8'h88);
    checks++; if (bus_if.oWord !== 32'h04030201 || bus_if.oValid !== 1'b1) begin errors++;
      $display("FAIL overrun_keep: got %h/%0h want 04030201/1", bus_if.oWord, bus_if.oValid); end
    mul = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (bus_if.oValid !== 1'b0) begin errors++;
      $display("FAIL overrun_ack: got %0h want 0", bus_if.oValid); end
    beat_tick(8'h05, 8'h9A); beat_tick(8'h05, 8'hBC);
    beat_tick(8'h05, 8'hDE); beat_tick(8'h05, 8'hF0);
    checks++; if (bus_if.oWord !== 32'hF0DEBC9A || bus_if.oValid !== 1'b1) begin errors++;
      $display("FAIL overrun_third: got %h/%0h want F0DEBC9A/1", bus_if.oWord, bus_if.oValid); end
    checks++; if (bus_if.oOverrun !== 1'b1) begin errors++;
      $display("FAIL overrun_sticky: got %0h want 1", bus_if.oOverrun); end
    release_word();
  endtask

  task automatic test_ack_beat();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    beat_tick(8'h05, 8'h11); beat_tick(8'h05, 8'h22);
    beat_tick(8'h05, 8'h33); beat_tick(8'h05, 8'h44);
    mul = 1'b0;
    tick();
    ack = 1'b1;
    beat_tick(8'h07, 8'hEF);
    ack = 1'b0;
    checks++; if (bus_if.oValid !== 1'b0 || bus_if.oOverrun !== 1'b0) begin errors++;
      $display("FAIL ackbeat_release: got valid=%0h ovr=%0h want 0/0", bus_if.oValid,
               bus_if.oOverrun); end
    checks++; if (bus_if.oAddr !== 8'h07) begin errors++;
      $display("FAIL ackbeat_addr: got %h want 07", bus_if.oAddr); end
    beat_tick(8'h07, 8'h01); beat_tick(8'h07, 8'h02); beat_tick(8'h07, 8'h03);
    checks++; if (bus_if.oWord !== 32'h030201EF || bus_if.oValid !== 1'b1) begin errors++;
      $display("FAIL ackbeat_word: got %h/%0h want 030201EF/1", bus_if.oWord, bus_if.oValid); end
    release_word();
  endtask

  task automatic test_addr_switch();
    beat_tick(8'h05, 8'h11);
    beat_tick(8'h05, 8'h22);
    beat_tick(8'h06, 8'h33);
    checks++; if (bus_if.oAbort !== 1'b1) begin errors++;
      $display("FAIL switch_abort: got %0h want 1", bus_if.oAbort); end
    checks++; if (bus_if.oAddr !== 8'h06) begin errors++;
      $display("FAIL switch_addr: got %h want 06", bus_if.oAddr); end
    beat_tick(8'h06, 8'h44); beat_tick(8'h06, 8'h55); beat_tick(8'h06, 8'h66);
    checks++; if (bus_if.oWord !== 32'h66554433 || bus_if.oValid !== 1'b1) begin errors++;
      $display("FAIL switch_word: got %h/%0h want 66554433/1", bus_if.oWord, bus_if.oValid); end
    release_word();
  endtask

  task automatic test_reset_mid();
    beat_tick(8'h05, 8'hC1);
    beat_tick(8'h05, 8'hC2);
    rst = 1'b1;
    beat_tick(8'h05, 8'hC3);
    rst = 1'b0;
    checks++; if ({bus_if.oValid, bus_if.oAbort, bus_if.oOverrun} !== 3'b000) begin errors++;
      $display("FAIL midreset_flags: got %b want 000",
               {bus_if.oValid, bus_if.oAbort, bus_if.oOverrun}); end
    checks++; if (bus_if.oWord !== 32'h0 || bus_if.oAddr !== 8'h0) begin errors++;
      $display("FAIL midreset_data: got %h/%h want 0/0", bus_if.oWord, bus_if.oAddr); end
    mul = 1'b0;
    tick();
    checks++; if (bus_if.oAbort !== 1'b0) begin errors++;
      $display("FAIL midreset_noabort: got %0h want 0", bus_if.oAbort); end
  endtask

`ifdef COLLECTOR_LED_EN
  task automatic test_led();
    logic [7:0] exp_led[5];
    exp_led[0] = 8'h78; exp_led[1] = 8'h56; exp_led[2] = 8'h34;
    exp_led[3] = 8'h12; exp_led[4] = 8'h78;
    beat_tick(8'h05, 8'h78); beat_tick(8'h05, 8'h56);
    beat_tick(8'h05, 8'h34); beat_tick(8'h05, 8'h12);
    mul = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus_if.oLed !== exp_led[k]) begin errors++;
        $display("FAIL led_step%0d: got %h want %h", k, bus_if.oLed, exp_led[k]); end
      repeat (8) tick();
    end
    release_word();
    checks++; if (bus_if.oLed !== 8'h00) begin errors++;
      $display("FAIL led_idle: got %h want 00", bus_if.oLed); end
  endtask
`endif

  task automatic test_random();
    logic [42:0] got, want;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) mul = ~mul;
      we    = mul ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
      waddr = ($urandom_range(0, 15) == 0) ? 8'h06 : 8'h05;
      wdata = 16'($urandom);
      ack   = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      tick();
      got  = {bus_if.oValid, bus_if.oAbort, bus_if.oOverrun, bus_if.oAddr, bus_if.oWord};
      want = {held_m, abort_m, ovr_m, paddr_m, word_m};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_cycle%0d: got v/a/o/addr/word=%h want %h", n, got, want);
      end
    end
    rst = 1'b0; mul = 1'b0; we = 1'b0; ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_overrun();
    test_ack_beat();
    test_addr_switch();
    test_reset_mid();
`ifdef COLLECTOR_LED_EN
    test_led();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
